// File: rtl/uart_command_controller.sv
`default_nettype none
// ============================================================================
// Module      : uart_command_controller
// Description : Parses framed commands (A5|CMD|LEN|PAYLOAD|CSUM) from the UART
//               receiver and drives joypads, a memory write port and NES reset.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_command_controller #(
    parameter int ADDR_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int RESET_CYCLES   = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [7:0]            rx_data_i,
    input  logic                  rx_valid_i,
    output logic                  rx_ready_o,
    output logic [7:0]            joypad1_o,
    output logic [7:0]            joypad2_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [7:0]            mem_data_o,
    output logic                  mem_wr_o,
    input  logic                  mem_ready_i,
    output logic                  nes_rst_o,
    output logic                  frame_ok_o,
    output logic                  frame_err_o,
    output logic [7:0]            err_count_o
);

    localparam int         c_TO_W      = $clog2(TIMEOUT_CYCLES + 1);
    localparam int         c_RC_W      = $clog2(RESET_CYCLES + 1);
    localparam logic [7:0] c_SYNC      = 8'hA5;
    localparam logic [7:0] c_CMD_JOY   = 8'h01;
    localparam logic [7:0] c_CMD_MEM   = 8'h02;
    localparam logic [7:0] c_CMD_RESET = 8'h03;

    typedef enum logic [3:0] {
        S_HUNT, S_CMD, S_LEN, S_ADDR_HI, S_ADDR_LO,
        S_PAYLOAD, S_MEM_WAIT, S_CSUM, S_EXEC, S_RST_PULSE
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            rst_sync_q, rst_sync_d;
    logic [7:0]            cmd_q, cmd_d, len_q, len_d, rem_q, rem_d, csum_q, csum_d;
    logic [7:0]            addr_hi_q, addr_hi_d, shadow1_q, shadow1_d, shadow2_q, shadow2_d;
    logic [7:0]            joy1_q, joy1_d, joy2_q, joy2_d, mem_data_q, mem_data_d;
    logic [7:0]            err_count_q, err_count_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  mem_wr_q, mem_wr_d, nes_rst_q, nes_rst_d;
    logic                  ok_q, ok_d, err_q, err_d, rx_ready_q, rx_ready_d;
    logic [c_TO_W-1:0]     to_q, to_d;
    logic [c_RC_W-1:0]     rcnt_q, rcnt_d;
    logic                  w_rst_n, w_accept, w_legal, w_in_frame, w_fail;
    logic [7:0]            w_byte_idx;

    // Reset asserts asynchronously but is released on a clock edge.
    assign rst_sync_d = {rst_sync_q[0], 1'b1};
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) rst_sync_q <= 2'b00;
        else          rst_sync_q <= rst_sync_d;
    end
    assign w_rst_n = rst_sync_q[1];

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        len_d       = len_q;
        rem_d       = rem_q;
        csum_d      = csum_q;
        addr_hi_d   = addr_hi_q;
        addr_d      = addr_q;
        shadow1_d   = shadow1_q;
        shadow2_d   = shadow2_q;
        joy1_d      = joy1_q;
        joy2_d      = joy2_q;
        mem_data_d  = mem_data_q;
        mem_wr_d    = mem_wr_q;
        nes_rst_d   = nes_rst_q;
        err_count_d = err_count_q;
        rcnt_d      = rcnt_q;
        ok_d        = 1'b0;
        err_d       = 1'b0;
        w_fail      = 1'b0;
        w_accept    = rx_valid_i & rx_ready_q;
        w_byte_idx  = len_q - rem_q;
        w_legal     = ((cmd_q == c_CMD_JOY)   && (len_q == 8'd2)) ||
                      ((cmd_q == c_CMD_MEM)   && (len_q >= 8'd3)) ||
                      ((cmd_q == c_CMD_RESET) && (len_q == 8'd0));
        w_in_frame  = (state_q == S_CMD) || (state_q == S_LEN) || (state_q == S_ADDR_HI) ||
                      (state_q == S_ADDR_LO) || (state_q == S_PAYLOAD) || (state_q == S_CSUM);

        case (state_q)
            S_HUNT: if (w_accept && rx_data_i == c_SYNC) state_d = S_CMD;
            S_CMD: if (w_accept) begin
                cmd_d   = rx_data_i;
                csum_d  = rx_data_i;
                state_d = S_LEN;
            end
            S_LEN: if (w_accept) begin
                len_d  = rx_data_i;
                rem_d  = rx_data_i;
                csum_d = csum_q ^ rx_data_i;
                if (rx_data_i == 8'd0)      state_d = S_CSUM;
                else if (cmd_q == c_CMD_MEM) state_d = S_ADDR_HI;
                else                         state_d = S_PAYLOAD;
            end
            S_ADDR_HI: if (w_accept) begin
                addr_hi_d = rx_data_i;
                csum_d    = csum_q ^ rx_data_i;
                rem_d     = rem_q - 8'd1;
                state_d   = (rem_q == 8'd1) ? S_CSUM : S_ADDR_LO;
            end
            S_ADDR_LO: if (w_accept) begin
                addr_d  = ADDR_WIDTH'({addr_hi_q, rx_data_i});
                csum_d  = csum_q ^ rx_data_i;
                rem_d   = rem_q - 8'd1;
                state_d = (rem_q == 8'd1) ? S_CSUM : S_PAYLOAD;
            end
            S_PAYLOAD: if (w_accept) begin
                csum_d  = csum_q ^ rx_data_i;
                rem_d   = rem_q - 8'd1;
                state_d = (rem_q == 8'd1) ? S_CSUM : S_PAYLOAD;
                if (cmd_q == c_CMD_JOY) begin
                    if (w_byte_idx == 8'd0) shadow1_d = rx_data_i;
                    if (w_byte_idx == 8'd1) shadow2_d = rx_data_i;
                end else if (cmd_q == c_CMD_MEM) begin
                    mem_data_d = rx_data_i;
                    mem_wr_d   = 1'b1;
                    state_d    = S_MEM_WAIT;
                end
            end
            S_MEM_WAIT: if (mem_ready_i) begin
                mem_wr_d = 1'b0;
                addr_d   = addr_q + ADDR_WIDTH'(1);
                state_d  = (rem_q == 8'd0) ? S_CSUM : S_PAYLOAD;
            end
            S_CSUM: if (w_accept) begin
                if (rx_data_i == csum_q && w_legal) state_d = S_EXEC;
                else                                w_fail  = 1'b1;
            end
            S_EXEC: begin
                ok_d = 1'b1;
                if (cmd_q == c_CMD_JOY) begin
                    joy1_d = shadow1_q;
                    joy2_d = shadow2_q;
                end
                if (cmd_q == c_CMD_RESET) begin
                    state_d   = S_RST_PULSE;
                    nes_rst_d = 1'b1;
                    rcnt_d    = '0;
                end else begin
                    state_d = S_HUNT;
                end
            end
            S_RST_PULSE: begin
                if (rcnt_q == c_RC_W'(RESET_CYCLES - 1)) begin
                    nes_rst_d = 1'b0;
                    state_d   = S_HUNT;
                end else begin
                    rcnt_d = rcnt_q + c_RC_W'(1);
                end
            end
            default: state_d = S_HUNT;
        endcase

        // Inter-byte timeout only runs while a frame is waiting for input.
        if (w_in_frame && !w_accept) begin
            if (to_q == c_TO_W'(TIMEOUT_CYCLES - 1)) begin
                w_fail = 1'b1;
                to_d   = '0;
            end else begin
                to_d = to_q + c_TO_W'(1);
            end
        end else begin
            to_d = '0;
        end

        if (w_fail) begin
            err_d   = 1'b1;
            state_d = S_HUNT;
            if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
        end

        rx_ready_d = (state_d != S_MEM_WAIT) && (state_d != S_EXEC) && (state_d != S_RST_PULSE);
    end

    always_ff @(posedge clk_i or negedge w_rst_n) begin
        if (!w_rst_n) begin
            state_q     <= S_HUNT;
            cmd_q       <= '0;
            len_q       <= '0;
            rem_q       <= '0;
            csum_q      <= '0;
            addr_hi_q   <= '0;
            addr_q      <= '0;
            shadow1_q   <= '0;
            shadow2_q   <= '0;
            joy1_q      <= '0;
            joy2_q      <= '0;
            mem_data_q  <= '0;
            mem_wr_q    <= 1'b0;
            nes_rst_q   <= 1'b0;
            err_count_q <= '0;
            rcnt_q      <= '0;
            to_q        <= '0;
            ok_q        <= 1'b0;
            err_q       <= 1'b0;
            rx_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            len_q       <= len_d;
            rem_q       <= rem_d;
            csum_q      <= csum_d;
            addr_hi_q   <= addr_hi_d;
            addr_q      <= addr_d;
            shadow1_q   <= shadow1_d;
            shadow2_q   <= shadow2_d;
            joy1_q      <= joy1_d;
            joy2_q      <= joy2_d;
            mem_data_q  <= mem_data_d;
            mem_wr_q    <= mem_wr_d;
            nes_rst_q   <= nes_rst_d;
            err_count_q <= err_count_d;
            rcnt_q      <= rcnt_d;
            to_q        <= to_d;
            ok_q        <= ok_d;
            err_q       <= err_d;
            rx_ready_q  <= rx_ready_d;
        end
    end

    assign rx_ready_o  = rx_ready_q;
    assign joypad1_o   = joy1_q;
    assign joypad2_o   = joy2_q;
    assign mem_addr_o  = addr_q;
    assign mem_data_o  = mem_data_q;
    assign mem_wr_o    = mem_wr_q;
    assign nes_rst_o   = nes_rst_q;
    assign frame_ok_o  = ok_q;
    assign frame_err_o = err_q;
    assign err_count_o = err_count_q;

endmodule
`default_nettype wire
